vis_centroid_calc: RTL and testbench
====================================

Name: vis_centroid_calc

Overview:
- Computes the centroid (x, y) of foreground pixels in a binarized video frame. It is the producer of the crosshair coordinates consumed by the overlay stage downstream.
- Taps the same de/hsync/vsync/pixel stream that feeds the overlay, accumulates image moments over one frame, and divides them at frame end.
- Holds the result stable for the whole next frame.

Parameters:
- IMG_W, 64, active pixels per line; x counter wraps at IMG_W-1.
- IMG_H, 64, active lines per frame; sizing only, no y wrap.
- ACC_W, 32, width of moment accumulators and of the divider; one divider iteration per bit.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- de  input  1  data enable, pixel valid
- hsync  input  1  horizontal sync, unused internally, kept for interface symmetry
- vsync  input  1  vertical sync, high during frame blanking
- pixel_in  input  24  binarized pixel, foreground when pixel_in[23:16] != 0
- x  output  11  centroid column, registered
- y  output  11  centroid row, registered
- valid  output  1  one-cycle pulse when x/y/obj_found update
- obj_found  output  1  1 = last frame held at least one foreground pixel
- busy  output  1  divider running

Behaviour:
- Reset, synchronous and active-high:
  - x=0, y=0, valid=0, obj_found=0, busy=0, FSM=IDLE.
  - Accumulators, position counters and vsync_d all cleared.
  - Reset overrides every other event, including during DIV; no valid pulse follows an aborted division.
- Position counters x_pos/y_pos, 11 bits:
  - vsync=1: both cleared.
  - Else, on de=1: x_pos increments; at x_pos==IMG_W-1 it wraps to 0 and y_pos increments.
- Accumulation, while vsync=0, for each de=1 cycle with a foreground pixel:
  - m00 += 1
  - m10 += x_pos
  - m01 += y_pos
  - All ACC_W bits, no saturation; the default frame size cannot overflow.
- Frame end:
  - vsync_d is registered vsync. The edge cycle E is the cycle with vsync=1 and vsync_d=0.
  - In IDLE at E: copy m00/m10/m01 into divider operand registers, clear the accumulators, go to DIV.
  - Not in IDLE at E: accumulators are still cleared, the frame result is dropped, and the running division continues unaffected.
  - de=1 while vsync=1 is ignored.
- FSM:
  - IDLE: busy=0; waits for E.
  - DIV: busy=1. Two restoring dividers run in parallel, m10/m00 and m01/m00, one quotient bit per cycle, MSB first, ACC_W cycles (E+1 .. E+ACC_W).
  - DONE, single cycle at E+ACC_W+1:
    - If m00 != 0: x and y take the low 11 bits of the quotients; obj_found=1.
    - If m00 == 0: x and y hold their previous values (divide-by-zero is never latched); obj_found=0.
    - valid=1 in both cases; next state is IDLE.
- Rounding: truncation (floor). Quotients never exceed IMG_W-1 / IMG_H-1.
- Latency: valid is high exactly ACC_W+1 cycles after E, so 33 cycles at the default.
- valid is low in every cycle other than DONE.
- x/y/obj_found change only in DONE or on reset.

Test Plan:
1. Single foreground pixel at (10,20) in a 64x64 frame, then vsync rise -> after 33 cycles valid=1 for 1 cycle, x=10, y=20, obj_found=1.
2. 2x2 block at columns 4..5, rows 6..7 -> m00=4, m10=18, m01=26 -> x=4, y=6, obj_found=1.
3. All 4096 pixels foreground -> m10=m01=129024 -> x=31, y=31.
4. Frame with no foreground after test 1 -> valid pulse with obj_found=0, x=10, y=20 held.
5. Second vsync rise 5 cycles into DIV with foreground pixels present -> the first result completes correctly, the second frame is dropped, and the next frame's accumulation starts from zero.
6. rst=1 at cycle 10 of DIV -> busy=0 the next cycle; x=0, y=0; no valid pulse for 40 cycles; a subsequent normal frame produces the correct result.

Source files
------------

// File: rtl/vis_centroid_calc.sv
// Frame centroid of foreground pixels: accumulates image moments while vsync is low,
// then divides them with two parallel restoring dividers once vsync rises.
`timescale 1ns/1ps
module vis_centroid_calc #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned ACC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] pixel_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        valid,
    output logic        obj_found,
    output logic        busy
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             vsync_d;
    logic [POS_W-1:0] x_pos, y_pos;
    logic [ACC_W-1:0] m00, m10, m01;

    logic [ACC_W-1:0] dvsr, nx, ny, qx, qy, rx, ry;
    logic [CNT_W-1:0] cnt;

    logic             frame_end_c, fg_c, acc_en_c;
    logic             load_c, step_c, done_c, busy_c, valid_c;
    logic [ACC_W:0]   rx_sh_c, ry_sh_c;
    logic             qx_bit_c, qy_bit_c;
    logic [ACC_W-1:0] rx_nxt_c, ry_nxt_c, qx_nxt_c, qy_nxt_c;
    logic             unused_sink;

    assign frame_end_c = vsync & ~vsync_d;
    assign fg_c        = |pixel_in[23:16];
    assign acc_en_c    = ~vsync & de & fg_c;
    assign unused_sink = ^{hsync, pixel_in[15:0], qx[ACC_W-1], qy[ACC_W-1]};

    // One restoring-division step for both quotients, MSB first
    always_comb begin
        rx_sh_c  = {rx, nx[ACC_W-1]};
        ry_sh_c  = {ry, ny[ACC_W-1]};
        qx_bit_c = (rx_sh_c >= {1'b0, dvsr});
        qy_bit_c = (ry_sh_c >= {1'b0, dvsr});
        rx_nxt_c = qx_bit_c ? ACC_W'(rx_sh_c - {1'b0, dvsr}) : rx_sh_c[ACC_W-1:0];
        ry_nxt_c = qy_bit_c ? ACC_W'(ry_sh_c - {1'b0, dvsr}) : ry_sh_c[ACC_W-1:0];
        qx_nxt_c = {qx[ACC_W-2:0], qx_bit_c};
        qy_nxt_c = {qy[ACC_W-2:0], qy_bit_c};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end_c) begin
                    state_nxt = DIV;
                    load_c    = 1'b1;
                end
            end
            DIV: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(ACC_W - 1)) begin
                    state_nxt = DONE;
                    done_c    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_c  = (state_nxt == DIV);
        valid_c = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) vsync_d <= 1'b0;
        else     vsync_d <= vsync;
    end

    // Raster position of the current active pixel
    always_ff @(posedge clk) begin
        if (rst || vsync) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (de) begin
            if (x_pos == POS_W'(IMG_W - 1)) begin
                x_pos <= '0;
                y_pos <= y_pos + POS_W'(1);
            end else begin
                x_pos <= x_pos + POS_W'(1);
            end
        end
    end

    // Moments restart at every frame end, whether or not the divider accepted them
    always_ff @(posedge clk) begin
        if (rst || frame_end_c) begin
            m00 <= '0;
            m10 <= '0;
            m01 <= '0;
        end else if (acc_en_c) begin
            m00 <= m00 + ACC_W'(1);
            m10 <= m10 + ACC_W'(x_pos);
            m01 <= m01 + ACC_W'(y_pos);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr <= '0;
            nx   <= '0;
            ny   <= '0;
            rx   <= '0;
            ry   <= '0;
            qx   <= '0;
            qy   <= '0;
            cnt  <= '0;
        end else if (load_c) begin
            dvsr <= m00;
            nx   <= m10;
            ny   <= m01;
            rx   <= '0;
            ry   <= '0;
            qx   <= '0;
            qy   <= '0;
            cnt  <= '0;
        end else if (step_c) begin
            nx   <= {nx[ACC_W-2:0], 1'b0};
            ny   <= {ny[ACC_W-2:0], 1'b0};
            rx   <= rx_nxt_c;
            ry   <= ry_nxt_c;
            qx   <= qx_nxt_c;
            qy   <= qy_nxt_c;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Results latch with the final quotient bit; an empty frame keeps the old coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            valid     <= 1'b0;
            obj_found <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= valid_c;
            busy  <= busy_c;
            if (done_c) begin
                obj_found <= (dvsr != '0);
                if (dvsr != '0) begin
                    x <= (qx_nxt_c > ACC_W'(IMG_W - 1)) ? POS_W'(IMG_W - 1) : qx_nxt_c[POS_W-1:0];
                    y <= (qy_nxt_c > ACC_W'(IMG_H - 1)) ? POS_W'(IMG_H - 1) : qy_nxt_c[POS_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_vis_centroid_calc.sv
// Self-checking bench for vis_centroid_calc: randomized frames compared against a
// centroid model computed directly from the list of foreground pixel positions.
`timescale 1ns/1ps
module tb_vis_centroid_calc;

    localparam int IMG_W = 64;
    localparam int LAT   = 33;

    logic        clk, rst, de, hsync, vsync;
    logic [23:0] pixel_in;
    logic [10:0] x, y;
    logic        valid, obj_found, busy;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    typedef struct {
        longint      cyc;
        logic [10:0] x;
        logic [10:0] y;
        logic        obj;
    } res_t;

    res_t        res_q[$];
    bit          frame_fg[$];
    logic [10:0] held_x = '0;
    logic [10:0] held_y = '0;

    vis_centroid_calc #(.IMG_W(64), .IMG_H(64), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
        .pixel_in(pixel_in), .x(x), .y(y), .valid(valid),
        .obj_found(obj_found), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every valid pulse with its cycle number
    always begin
        res_t r;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (valid === 1'b1) begin
            r.cyc = cyc; r.x = x; r.y = y; r.obj = obj_found;
            res_q.push_back(r);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Centroid of the current frame list; coordinates held when it is empty
    task automatic model_frame(output logic [10:0] ex, output logic [10:0] ey, output logic eo);
        longint n = 0, sx = 0, sy = 0;
        foreach (frame_fg[k]) begin
            if (frame_fg[k]) begin
                n++;
                sx += k % IMG_W;
                sy += k / IMG_W;
            end
        end
        if (n != 0) begin
            held_x = 11'(sx / n);
            held_y = 11'(sy / n);
        end
        ex = held_x; ey = held_y; eo = (n != 0);
    endtask

    task automatic drive_frame(input int gap_pct);
        logic [23:0] p;
        vsync = 1'b0;
        foreach (frame_fg[k]) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                de = 1'b0; pixel_in = 24'($urandom);
                tick();
            end
            p = 24'($urandom);
            p[23:16] = frame_fg[k] ? 8'($urandom_range(1, 255)) : 8'h00;
            de = 1'b1; pixel_in = p;
            tick();
        end
        de = 1'b0; pixel_in = '0;
    endtask

    task automatic end_frame(output longint e);
        vsync = 1'b1; de = 1'b0;
        e = cyc;
        tick();
    endtask

    // Waits (bounded) for the next valid pulse while feeding stray de during blanking
    task automatic collect_result(output bit got, output res_t r);
        got = 1'b0;
        r.cyc = 0; r.x = 'x; r.y = 'x; r.obj = 'x;
        for (int n = 0; n < 80 && res_q.size() == 0; n++) begin
            de = 1'($urandom_range(0, 1)); pixel_in = 24'($urandom);
            tick();
        end
        de = 1'b0; pixel_in = '0;
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic fill_frame(input int n, input int pct);
        frame_fg.delete();
        for (int i = 0; i < n; i++) frame_fg.push_back($urandom_range(0, 99) < pct);
    endtask

    task automatic test_reset();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = '0;
        repeat (3) tick();
        checks++; if (x !== 11'd0) begin errors++; $display("FAIL reset_x: got %0d expected 0", x); end
        checks++; if (y !== 11'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (obj_found !== 1'b0) begin errors++; $display("FAIL reset_obj: got %b expected 0", obj_found); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (2) tick();
        frame_fg.delete();
        model_frame(ex, ey, eo);
        end_frame(e);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL reset_empty_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== ex || r.y !== ey || r.obj !== eo) begin errors++; $display("FAIL reset_empty_res: got (%0d,%0d,%b) expected (%0d,%0d,%b)", r.x, r.y, r.obj, ex, ey, eo); end
    endtask

    task automatic test_single_pixel();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        frame_fg.delete();
        for (int i = 0; i < 4096; i++) frame_fg.push_back(i == 20 * IMG_W + 10);
        model_frame(ex, ey, eo);
        drive_frame(10);
        end_frame(e);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL single_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== 11'd10 || r.y !== 11'd20 || r.obj !== 1'b1) begin errors++; $display("FAIL single_res: got (%0d,%0d,%b) expected (10,20,1)", r.x, r.y, r.obj); end
        checks++; if (ex !== 11'd10 || ey !== 11'd20) begin errors++; $display("FAIL single_model: model (%0d,%0d) expected (10,20)", ex, ey); end
        repeat (2) tick();
        checks++; if (res_q.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: extra pulses %0d valid %b expected 0/0", res_q.size(), valid); end
    endtask

    task automatic test_empty();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        fill_frame(4096, 0);
        model_frame(ex, ey, eo);
        drive_frame(5);
        end_frame(e);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL empty_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== 11'd10 || r.y !== 11'd20 || r.obj !== 1'b0) begin errors++; $display("FAIL empty_res: got (%0d,%0d,%b) expected (10,20,0)", r.x, r.y, r.obj); end
        checks++; if (r.x !== ex || r.y !== ey || r.obj !== eo) begin errors++; $display("FAIL empty_model: got (%0d,%0d,%b) expected (%0d,%0d,%b)", r.x, r.y, r.obj, ex, ey, eo); end
    endtask

    task automatic test_block();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        frame_fg.delete();
        for (int i = 0; i < 4096; i++)
            frame_fg.push_back((i % IMG_W) inside {4, 5} && (i / IMG_W) inside {6, 7});
        model_frame(ex, ey, eo);
        drive_frame(10);
        end_frame(e);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL block_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== 11'd4 || r.y !== 11'd6 || r.obj !== 1'b1) begin errors++; $display("FAIL block_res: got (%0d,%0d,%b) expected (4,6,1)", r.x, r.y, r.obj); end
    endtask

    task automatic test_full();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        fill_frame(4096, 100);
        model_frame(ex, ey, eo);
        drive_frame(10);
        end_frame(e);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL full_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== 11'd31 || r.y !== 11'd31 || r.obj !== 1'b1) begin errors++; $display("FAIL full_res: got (%0d,%0d,%b) expected (31,31,1)", r.x, r.y, r.obj); end
    endtask

    task automatic test_random_frames();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        for (int f = 0; f < 5; f++) begin
            fill_frame($urandom_range(100, 4096), (f == 0) ? 1 : $urandom_range(0, 100));
            model_frame(ex, ey, eo);
            drive_frame($urandom_range(0, 30));
            end_frame(e);
            collect_result(got, r);
            checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL rand%0d_lat: got=%0b latency %0d expected %0d", f, got, r.cyc - e, LAT); end
            checks++; if (r.x !== ex || r.y !== ey || r.obj !== eo) begin errors++; $display("FAIL rand%0d_res: got (%0d,%0d,%b) expected (%0d,%0d,%b)", f, r.x, r.y, r.obj, ex, ey, eo); end
            checks++; if (x !== ex || y !== ey || obj_found !== eo) begin errors++; $display("FAIL rand%0d_hold: got (%0d,%0d,%b) expected (%0d,%0d,%b)", f, x, y, obj_found, ex, ey, eo); end
        end
    endtask

    task automatic test_back_to_back();
        longint e1, e2; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        fill_frame(1500, 20);
        model_frame(ex, ey, eo);
        drive_frame(10);
        end_frame(e1);
        repeat (4) tick();
        vsync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            de = 1'b1; pixel_in = 24'hFF0000;
            tick();
        end
        end_frame(e2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        collect_result(got, r);
        checks++; if (!got || r.cyc - e1 != LAT) begin errors++; $display("FAIL b2b_lat: got=%0b latency %0d expected %0d", got, r.cyc - e1, LAT); end
        checks++; if (r.x !== ex || r.y !== ey || r.obj !== eo) begin errors++; $display("FAIL b2b_first: got (%0d,%0d,%b) expected (%0d,%0d,%b)", r.x, r.y, r.obj, ex, ey, eo); end
        repeat (45) tick();
        checks++; if (res_q.size() != 0) begin errors++; $display("FAIL b2b_dropped: got %0d pulses expected 0", res_q.size()); end
        frame_fg.delete();
        for (int i = 0; i < 256; i++) frame_fg.push_back(i == 3 * IMG_W + 50);
        model_frame(ex, ey, eo);
        drive_frame(0);
        end_frame(e1);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e1 != LAT) begin errors++; $display("FAIL b2b_next_lat: got=%0b latency %0d expected %0d", got, r.cyc - e1, LAT); end
        checks++; if (r.x !== 11'd50 || r.y !== 11'd3 || r.obj !== 1'b1) begin errors++; $display("FAIL b2b_next_res: got (%0d,%0d,%b) expected (50,3,1)", r.x, r.y, r.obj); end
    endtask

    task automatic test_reset_during_div();
        longint e; bit got; res_t r; logic [10:0] ex, ey; logic eo;
        fill_frame(2000, 30);
        model_frame(ex, ey, eo);
        drive_frame(5);
        end_frame(e);
        repeat (4) tick();
        vsync = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divrst_busy: got %b expected 0", busy); end
        checks++; if (x !== 11'd0 || y !== 11'd0) begin errors++; $display("FAIL divrst_xy: got (%0d,%0d) expected (0,0)", x, y); end
        checks++; if (obj_found !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL divrst_flags: got obj %b valid %b expected 0/0", obj_found, valid); end
        rst = 1'b0;
        held_x = '0; held_y = '0;
        res_q.delete();
        repeat (40) tick();
        checks++; if (res_q.size() != 0) begin errors++; $display("FAIL divrst_no_valid: got %0d pulses expected 0", res_q.size()); end
        fill_frame(3000, 15);
        model_frame(ex, ey, eo);
        drive_frame(10);
        end_frame(e);
        collect_result(got, r);
        checks++; if (!got || r.cyc - e != LAT) begin errors++; $display("FAIL divrst_next_lat: got=%0b latency %0d expected %0d", got, r.cyc - e, LAT); end
        checks++; if (r.x !== ex || r.y !== ey || r.obj !== eo) begin errors++; $display("FAIL divrst_next_res: got (%0d,%0d,%b) expected (%0d,%0d,%b)", r.x, r.y, r.obj, ex, ey, eo); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_empty();
        test_block();
        test_full();
        test_random_frames();
        test_back_to_back();
        test_reset_during_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
